// File: rtl/for_xout_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : for_xout_acc_if
// Description : Sample-in / sum-out valid-ready streams of the XOUT window
//               accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface for_xout_acc_if #(
    parameter int NX   = 8,
    parameter int NACC = 16
);
    logic [NX-1:0]   XIN;
    logic            XIN_VALID;
    logic            XIN_READY;
    logic [NACC-1:0] SUM;
    logic            SUM_VALID;
    logic            SUM_READY;
    logic            OVF;

    // Upstream producer plus downstream consumer of the accumulator.
    modport master (
        output XIN, XIN_VALID, SUM_READY,
        input  XIN_READY, SUM, SUM_VALID, OVF
    );

    modport slave (
        input  XIN, XIN_VALID, SUM_READY,
        output XIN_READY, SUM, SUM_VALID, OVF
    );
endinterface
`default_nettype wire

// File: rtl/for_xout_acc.sv
`default_nettype none
// ============================================================================
// Module      : for_xout_acc
// Description : Sums WINDOW consecutive accepted XOUT samples into one SUM.
//               Saturating add with OVF flag when FOR_XOUT_ACC_SAT_EN is
//               defined; wrapping add with OVF tied low otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module for_xout_acc #(
    parameter int NX     = 8,
    parameter int NACC   = 16,
    parameter int WINDOW = 4
) (
    input  logic           CLK,
    input  logic           RST,
    for_xout_acc_if.slave  bus
);

    localparam int                 c_cnt_w = $clog2(WINDOW) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WINDOW - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NACC-1:0]    r_acc;
    logic [NACC-1:0]    w_acc_nxt;
    logic [NACC-1:0]    r_sum;
    logic [NACC-1:0]    w_sum_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_sum_valid;
    logic               w_sum_valid_nxt;
    logic               w_accept;
    logic               w_last;
    logic               w_release;
    logic [NACC-1:0]    w_add;

    assign w_accept  = bus.XIN_VALID && (r_state == ST_ACCUM);
    assign w_last    = (r_cnt == c_last);
    assign w_release = (r_state == ST_HOLD) && bus.SUM_READY;

`ifdef FOR_XOUT_ACC_SAT_EN
    logic [NACC:0] w_wide;
    logic          w_sat_now;
    logic          r_sat;
    logic          r_ovf;

    assign w_wide    = {1'b0, r_acc} + (NACC + 1)'(bus.XIN);
    // Once any add in the window carries out, the rest of the window stays clamped.
    assign w_sat_now = r_sat | w_wide[NACC];
    assign w_add     = w_sat_now ? {NACC{1'b1}} : w_wide[NACC-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sat <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_ovf <= w_sat_now;
                r_sat <= 1'b0;
            end else begin
                r_sat <= w_sat_now;
            end
        end else if (w_release) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.OVF = r_ovf;
`else
    assign w_add   = r_acc + NACC'(bus.XIN);
    assign bus.OVF = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sum       <= w_sum_nxt;
            r_sum_valid <= w_sum_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_sum_nxt       = r_sum;
        w_sum_valid_nxt = r_sum_valid;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_sum_nxt       = w_add;
                        w_sum_valid_nxt = 1'b1;
                        w_acc_nxt       = '0;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = ST_HOLD;
                    end else begin
                        w_acc_nxt = w_add;
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // SUM keeps its value after the handshake; only the valid drops.
                if (bus.SUM_READY) begin
                    w_sum_valid_nxt = 1'b0;
                    w_state_nxt     = ST_ACCUM;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    assign bus.XIN_READY = (r_state == ST_ACCUM);
    assign bus.SUM       = r_sum;
    assign bus.SUM_VALID = r_sum_valid;

endmodule
`default_nettype wire

// File: doc/for_xout_acc.md
Name: for_xout_acc

Overview:
Downstream consumer of the ForEnt datapath (XOUT = (5*A) - B mod 256, for count=4). It accepts XOUT samples over a valid/ready stream and accumulates a fixed window of WINDOW samples into a wider sum. Each completed sum is handed off over a second valid/ready stream. It is the first registered stage after the combinational ForEnt block.

Parameters:
NX, 8, width of the incoming XOUT sample (matches ForEnt output)
NACC, 16, accumulator and SUM width; must be >= NX
WINDOW, 4, samples per sum; must be >= 1; counter width is clog2(WINDOW)+1

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous, active-high reset
XIN  input  NX  sample from ForEnt XOUT, unsigned
XIN_VALID  input  1  XIN holds a valid sample
XIN_READY  output  1  block can accept a sample this cycle
SUM  output  NACC  completed window sum, unsigned
SUM_VALID  output  1  SUM holds a completed window
SUM_READY  input  1  consumer accepts SUM this cycle
OVF  output  1  window overflowed NACC (see Optional Feature)

Behaviour:
- Reset (RST high at a CLK edge): state=ACCUM, acc=0, cnt=0, SUM=0, SUM_VALID=0, OVF=0. Reset applies mid-window or mid-HOLD; partial sums and pending SUM are discarded.
- XIN_READY = (state == ACCUM). It is decoded from the state register only, with no combinational path from SUM_READY.
- Accept: XIN_VALID && XIN_READY at a CLK edge. XIN is zero-extended to NACC before the add.
- State ACCUM:
  - On accept with cnt < WINDOW-1: acc <= acc + XIN, cnt <= cnt+1.
  - On accept with cnt == WINDOW-1: SUM <= acc + XIN, SUM_VALID <= 1, acc <= 0, cnt <= 0, state <= HOLD.
  - No accept: hold all registers.
- State HOLD:
  - XIN_READY=0. SUM, SUM_VALID and OVF stay stable until the handshake.
  - SUM_READY high: SUM_VALID <= 0, OVF <= 0, state <= ACCUM.
  - SUM keeps its last value after the handshake; it is valid only while SUM_VALID is high.
- Latency: SUM_VALID rises on the edge that accepts the WINDOW-th sample, so it is visible in the following cycle.
- Throughput: one bubble per window. XIN_READY is low for at least one cycle after each sum.
- WINDOW=1: every accept goes directly to HOLD with SUM = XIN.
- Gaps in XIN_VALID are allowed. Only accepted samples count.
- XIN_VALID high during HOLD is ignored. The upstream must hold XIN until it is accepted.
- All arithmetic is unsigned. The overflow policy follows the macro below.

Optional Feature:
- Macro: FOR_XOUT_ACC_SAT_EN
- Defined:
  - The add is computed at NACC+1 bits.
  - If the carry is set, or the window has already saturated, acc/SUM are clamped to 2^NACC-1 for the rest of the window.
  - A sticky per-window flag is set and presented as OVF together with SUM_VALID.
  - OVF is cleared on the SUM handshake and on reset.
- Undefined:
  - The add wraps modulo 2^NACC.
  - OVF is tied to 0.
  - No extra register is required.

Test Plan:
- Default params, samples 10,20,30,40 with continuous XIN_VALID and SUM_READY=1 -> SUM=100, SUM_VALID high for exactly one cycle, starting the cycle after the 4th accept; XIN_READY low that same cycle.
- Drive ForEnt with (A,B) = (3,5), (10,0), (60,44), (2,9): XOUT = 10, 50, 0, 1 -> SUM=61.
- Backpressure: after a window of 1,1,1,1, hold SUM_READY=0 for 3 cycles -> SUM=4 and SUM_VALID held stable, XIN_READY=0 throughout, XIN_VALID ignored; assert SUM_READY -> SUM_VALID drops next cycle and XIN_READY returns.
- Gapped input: XIN_VALID high on alternate cycles with values 7,7,7,7 and junk XIN on invalid cycles -> SUM=28, junk values not accumulated.
- Reset mid-window: accept 100,100, pulse RST for one cycle, then accept 1,2,3,4 -> SUM=10, OVF=0.
- NACC=9, four samples of 255 -> with FOR_XOUT_ACC_SAT_EN: SUM=511, OVF=1; without: SUM=508 (1020 mod 512), OVF=0.
